mux_lectura_registros: RTL
==========================

Name: mux_lectura_registros

Overview:
- PicoBlaze input-port multiplexer for the RTC time/date/timer register file; read-side counterpart of the write-hold decoder.
- Presents snapshot copies of the nine BCD fields and a status byte on in_port, selected by port_id.
- Snapshot locking guarantees coherent multi-byte reads.
- Sticky event flags are cleared on read.

Parameters:
- LOCK_TIMEOUT, 255, clock cycles after which an open snapshot lock auto-releases. Used only with the optional feature.
- PORT_STATUS, 8'h02, port_id of the status register.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- port_id  input  8  PicoBlaze port address
- read_strobe  input  1  PicoBlaze read strobe, one-cycle pulse
- actualiza  input  1  one-cycle pulse: live fields below hold fresh RTC data
- timer_fin  input  1  one-cycle pulse: countdown timer reached zero
- seg_hora, min_hora, hora_hora  input  8 each  live time fields, BCD
- dia_fecha, mes_fecha, jahr_fecha  input  8 each  live date fields, BCD
- seg_timer, min_timer, hora_timer  input  8 each  live timer fields, BCD
- in_port  output  8  registered read data to PicoBlaze
- flag_pendiente  output  1  OR of status flags, usable as interrupt request

Behaviour:
- Reset:
  - in_port = 8'h00.
  - All nine snapshot registers = 8'h00.
  - Status flags = 0, both locks = 0, flag_pendiente = 0.
  - Lock counters = 0.
- Address map for in_port:
  - 0x03..0x08: seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha, jahr_fecha snapshots.
  - 0x0A..0x0C: seg_timer, min_timer, hora_timer snapshots.
  - PORT_STATUS: {6'b0, dato_nuevo, timer_fin_flag}.
  - Any other address: 8'h00.
- in_port timing:
  - in_port <= mux(port_id) on every clk edge, independent of read_strobe.
  - Latency is one cycle.
  - PicoBlaze holds port_id for two cycles before read_strobe, so the data is valid when read_strobe is sampled.
- Snapshots are grouped:
  - Group H = 0x03..0x08, with lock_h.
  - Group T = 0x0A..0x0C, with lock_t.
- Snapshot loading:
  - On actualiza, group H loads from the live inputs if lock_h = 0.
  - On actualiza, group T loads from the live inputs if lock_t = 0.
  - A locked group ignores actualiza; there is no deferred reload.
- Lock FSM per group, states LIBRE and BLOQUEADO:
  - LIBRE -> BLOQUEADO on read_strobe with port_id = first address of the group (0x03 or 0x0A).
  - BLOQUEADO -> LIBRE on read_strobe with port_id = last address of the group (0x08 or 0x0C).
  - Reading the first address again while BLOQUEADO keeps the lock.
  - A first-address read and actualiza in the same cycle: the lock wins and the snapshot is not reloaded that cycle.
  - If first address = last address (not the case with the current map), the lock is not taken.
- Flag dato_nuevo:
  - Set on an actualiza that reloads group H.
  - Cleared on read_strobe with port_id = PORT_STATUS.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Flag timer_fin_flag:
  - Set on timer_fin.
  - Clear rule identical to dato_nuevo, set wins.
- flag_pendiente = dato_nuevo | timer_fin_flag, registered (same cycle as the flags).
- Reset mid-lock: all locks drop to LIBRE and snapshots clear, regardless of state.
- No arithmetic on the data. BCD values pass through unchanged.

Optional Feature:
- Macro MUX_LECTURA_LOCK_TIMEOUT_EN, defined: each group has an 8-bit cycle counter.
  - The counter clears on entering BLOQUEADO.
  - It increments each cycle while BLOQUEADO.
  - When it reaches LOCK_TIMEOUT, the group returns to LIBRE on the next edge.
  - A read of the first address while BLOQUEADO restarts the counter.
- Macro undefined: no counters; a lock persists until the last-address read or reset.

Test Plan:
- Reset, then port_id=0x03 with no actualiza -> in_port=8'h00 one cycle later; flag_pendiente=0.
- Live seg_hora=8'h59, actualiza pulse, port_id=0x03 -> in_port=8'h59 next cycle; status read returns 8'h02; after read_strobe on 0x02, the status read returns 8'h00.
- Lock coherence:
  - Snapshot seg=8'h59, min=8'h12. Read 0x03.
  - Then live seg=8'h00, min=8'h13 with an actualiza pulse.
  - Read 0x04 -> 8'h12 (old min).
  - Read 0x08; next actualiza; read 0x04 -> 8'h13.
- timer_fin pulse in the same cycle as read_strobe on 0x02 -> timer_fin_flag remains 1; the next status read returns 8'h01.
- Unmapped port_id=0x09 and 0xFF -> in_port=8'h00. With the macro defined and LOCK_TIMEOUT=16: lock_h taken, no last-address read, actualiza after 20 cycles -> snapshot updates.
- Reset asserted while lock_t is BLOQUEADO -> next actualiza loads group T; reading 0x0A shows the new value.

Source files
------------

// File: rtl/mux_lectura_registros.sv
// PicoBlaze input-port multiplexer for the RTC register file: snapshot groups with read locks.
// Optional lock auto-release enabled by defining MUX_LECTURA_LOCK_TIMEOUT_EN.
module mux_lectura_registros #(
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter logic [7:0]  PORT_STATUS  = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       actualiza,
  input  logic       timer_fin,
  input  logic [7:0] seg_hora,
  input  logic [7:0] min_hora,
  input  logic [7:0] hora_hora,
  input  logic [7:0] dia_fecha,
  input  logic [7:0] mes_fecha,
  input  logic [7:0] jahr_fecha,
  input  logic [7:0] seg_timer,
  input  logic [7:0] min_timer,
  input  logic [7:0] hora_timer,
  output logic [7:0] in_port,
  output logic       flag_pendiente
);

  localparam logic [7:0] ADDR_H_FIRST = 8'h03;
  localparam logic [7:0] ADDR_H_LAST  = 8'h08;
  localparam logic [7:0] ADDR_T_FIRST = 8'h0A;
  localparam logic [7:0] ADDR_T_LAST  = 8'h0C;

  localparam logic LIBRE     = 1'b0;
  localparam logic BLOQUEADO = 1'b1;

  logic [7:0] snap_h_q [6];
  logic [7:0] snap_t_q [3];
  logic [7:0] live_h [6];
  logic [7:0] live_t [3];
  logic       lock_h_q, lock_h_d, lock_t_q, lock_t_d;
  logic       dato_nuevo_q, dato_nuevo_d, timer_fin_flag_q, timer_fin_flag_d;
  logic       take_h, take_t, rel_h, rel_t, rd_status, reload_h, reload_t;
  logic       timeout_h, timeout_t;
  logic [7:0] mux_data;

  assign live_h = '{seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha, jahr_fecha};
  assign live_t = '{seg_timer, min_timer, hora_timer};

  // A group whose first and last address coincide never takes the lock.
  assign take_h    = read_strobe && (port_id == ADDR_H_FIRST) && (ADDR_H_FIRST != ADDR_H_LAST);
  assign take_t    = read_strobe && (port_id == ADDR_T_FIRST) && (ADDR_T_FIRST != ADDR_T_LAST);
  assign rel_h     = read_strobe && (port_id == ADDR_H_LAST);
  assign rel_t     = read_strobe && (port_id == ADDR_T_LAST);
  assign rd_status = read_strobe && (port_id == PORT_STATUS);

  // Taking the lock beats a coincident reload.
  assign reload_h = actualiza && (lock_h_q == LIBRE) && !take_h;
  assign reload_t = actualiza && (lock_t_q == LIBRE) && !take_t;

`ifdef MUX_LECTURA_LOCK_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_VAL = LOCK_TIMEOUT[7:0];
  logic [7:0] cnt_h_q, cnt_h_d, cnt_t_q, cnt_t_d;

  assign timeout_h = (cnt_h_q == TIMEOUT_VAL);
  assign timeout_t = (cnt_t_q == TIMEOUT_VAL);

  always_comb begin
    cnt_h_d = 8'h00;
    cnt_t_d = 8'h00;
    if (lock_h_d == BLOQUEADO && lock_h_q == BLOQUEADO && !take_h) cnt_h_d = cnt_h_q + 8'd1;
    if (lock_t_d == BLOQUEADO && lock_t_q == BLOQUEADO && !take_t) cnt_t_d = cnt_t_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_h_q <= 8'h00;
      cnt_t_q <= 8'h00;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_t_q <= cnt_t_d;
    end
  end
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
  assign timeout_h = 1'b0;
  assign timeout_t = 1'b0;
`endif

  always_comb begin
    lock_h_d = lock_h_q;
    case (lock_h_q)
      LIBRE:     if (take_h) lock_h_d = BLOQUEADO;
      BLOQUEADO: if (rel_h || (timeout_h && !take_h)) lock_h_d = LIBRE;
      default:   lock_h_d = LIBRE;
    endcase
    lock_t_d = lock_t_q;
    case (lock_t_q)
      LIBRE:     if (take_t) lock_t_d = BLOQUEADO;
      BLOQUEADO: if (rel_t || (timeout_t && !take_t)) lock_t_d = LIBRE;
      default:   lock_t_d = LIBRE;
    endcase
  end

  // Set wins over clear-on-read.
  always_comb begin
    dato_nuevo_d     = reload_h  ? 1'b1 : (rd_status ? 1'b0 : dato_nuevo_q);
    timer_fin_flag_d = timer_fin ? 1'b1 : (rd_status ? 1'b0 : timer_fin_flag_q);
  end

  always_comb begin
    case (port_id)
      8'h03:       mux_data = snap_h_q[0];
      8'h04:       mux_data = snap_h_q[1];
      8'h05:       mux_data = snap_h_q[2];
      8'h06:       mux_data = snap_h_q[3];
      8'h07:       mux_data = snap_h_q[4];
      8'h08:       mux_data = snap_h_q[5];
      8'h0A:       mux_data = snap_t_q[0];
      8'h0B:       mux_data = snap_t_q[1];
      8'h0C:       mux_data = snap_t_q[2];
      PORT_STATUS: mux_data = {6'b0, dato_nuevo_q, timer_fin_flag_q};
      default:     mux_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) snap_h_q[i] <= 8'h00;
      for (int i = 0; i < 3; i++) snap_t_q[i] <= 8'h00;
      lock_h_q         <= LIBRE;
      lock_t_q         <= LIBRE;
      dato_nuevo_q     <= 1'b0;
      timer_fin_flag_q <= 1'b0;
      flag_pendiente   <= 1'b0;
      in_port          <= 8'h00;
    end else begin
      if (reload_h) for (int i = 0; i < 6; i++) snap_h_q[i] <= live_h[i];
      if (reload_t) for (int i = 0; i < 3; i++) snap_t_q[i] <= live_t[i];
      lock_h_q         <= lock_h_d;
      lock_t_q         <= lock_t_d;
      dato_nuevo_q     <= dato_nuevo_d;
      timer_fin_flag_q <= timer_fin_flag_d;
      flag_pendiente   <= dato_nuevo_d | timer_fin_flag_d;
      in_port          <= mux_data;
    end
  end

endmodule
